// File: rtl/seq_chk_pkg.sv
// rtl/seq_chk_pkg.sv - shared types for the sequence repetition checker
package seq_chk_pkg;

  typedef enum logic [1:0] {
    REP_CONSEC,
    REP_NONCONSEC,
    REP_GOTO,
    REP_RSVD
  } rep_mode_e;

  typedef enum logic {
    CHK_IDLE,
    CHK_OBSERVE
  } chk_state_e;

endpackage

// File: rtl/seq_repetition_checker_if.sv
// rtl/seq_repetition_checker_if.sv - config, trigger/event and verdict bundle
interface seq_repetition_checker_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 8
);
  logic              en;
  logic [1:0]        mode;
  logic [CNT_W-1:0]  min_rep;
  logic [CNT_W-1:0]  max_rep;
  logic [CNT_W-1:0]  win_len;
  logic [NUM_CH-1:0] a;
  logic [NUM_CH-1:0] b;
  logic [NUM_CH-1:0] pass;
  logic [NUM_CH-1:0] fail;
  logic [NUM_CH-1:0] drop;
  logic [NUM_CH-1:0] busy;

  modport master (
    output en, mode, min_rep, max_rep, win_len, a, b,
    input  pass, fail, drop, busy
  );

  modport slave (
    input  en, mode, min_rep, max_rep, win_len, a, b,
    output pass, fail, drop, busy
  );
endinterface

// File: rtl/seq_chk_channel.sv
// rtl/seq_chk_channel.sv - one a ##1 b[rep] checker: FSM, counters, latched config
module seq_chk_channel
  import seq_chk_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  rep_mode_e        mode_i,
  input  logic [CNT_W-1:0] min_rep_i,
  input  logic [CNT_W-1:0] max_rep_i,
  input  logic [CNT_W-1:0] win_len_i,
  input  logic             a_i,
  input  logic             b_i,
  output logic             pass_o,
  output logic             fail_o,
  output logic             drop_o,
  output logic             busy_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  chk_state_e       state_q, state_d;
  rep_mode_e        mode_q;
  logic [CNT_W-1:0] min_q, max_q, win_q, elapsed_q, cnt_q;
  logic [CNT_W-1:0] elapsed_nxt, cnt_nxt;
  logic             observing, trigger, win_end, decide, verdict;
  logic             pass_d, fail_d, drop_d, pass_q, fail_q, drop_q;

  assign observing   = (state_q == CHK_OBSERVE);
  assign trigger     = (state_q == CHK_IDLE) && en_i && a_i;
  assign elapsed_nxt = (elapsed_q == CNT_MAX) ? elapsed_q : elapsed_q + CNT_ONE;
  assign cnt_nxt     = (b_i && (cnt_q != CNT_MAX)) ? cnt_q + CNT_ONE : cnt_q;
  assign win_end     = (elapsed_nxt == win_q);

  // b-driven outcomes are tested before window expiry so they win on a shared edge
  always_comb begin
    decide  = 1'b0;
    verdict = 1'b0;
    case (mode_q)
      REP_CONSEC: begin
        if (min_q == '0 || (b_i && cnt_nxt >= min_q)) begin
          decide  = 1'b1;
          verdict = 1'b1;
        end else if (!b_i || win_end) begin
          decide = 1'b1;
        end
      end
      REP_GOTO: begin
        if (min_q == '0 || (b_i && cnt_nxt >= min_q)) begin
          decide  = 1'b1;
          verdict = 1'b1;
        end else if (win_end) begin
          decide = 1'b1;
        end
      end
      REP_NONCONSEC: begin
        if (max_q < min_q || cnt_nxt > max_q) begin
          decide = 1'b1;
        end else if (win_end) begin
          decide  = 1'b1;
          verdict = (cnt_nxt >= min_q);
        end
      end
      default: decide = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= CHK_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      CHK_IDLE:    if (en_i && a_i) state_d = CHK_OBSERVE;
      CHK_OBSERVE: if (!en_i || decide) state_d = CHK_IDLE;
      default:     state_d = CHK_IDLE;
    endcase
  end

  always_comb begin
    pass_d = 1'b0;
    fail_d = 1'b0;
    drop_d = 1'b0;
    if (observing && en_i) begin
      drop_d = a_i;
      pass_d = decide && verdict;
      fail_d = decide && !verdict;
    end
  end

  // window length 0 behaves as a single-cycle window
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mode_q    <= REP_CONSEC;
      min_q     <= '0;
      max_q     <= '0;
      win_q     <= CNT_ONE;
      elapsed_q <= '0;
      cnt_q     <= '0;
    end else if (trigger) begin
      mode_q    <= mode_i;
      min_q     <= min_rep_i;
      max_q     <= max_rep_i;
      win_q     <= (win_len_i == '0) ? CNT_ONE : win_len_i;
      elapsed_q <= '0;
      cnt_q     <= '0;
    end else if (observing) begin
      elapsed_q <= elapsed_nxt;
      cnt_q     <= cnt_nxt;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pass_q <= 1'b0;
      fail_q <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      pass_q <= pass_d;
      fail_q <= fail_d;
      drop_q <= drop_d;
    end
  end

  assign pass_o = pass_q;
  assign fail_o = fail_q;
  assign drop_o = drop_q;
  assign busy_o = observing;

endmodule

// File: rtl/seq_repetition_checker.sv
// rtl/seq_repetition_checker.sv - multi-channel a ##1 b[rep] monitor top
module seq_repetition_checker
  import seq_chk_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  seq_repetition_checker_if.slave   chk
);

  logic [NUM_CH-1:0] pass_w, fail_w, drop_w, busy_w;
  rep_mode_e         mode_w;

  assign mode_w = rep_mode_e'(chk.mode);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    seq_chk_channel #(.CNT_W(CNT_W)) u_ch (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .en_i      (chk.en),
      .mode_i    (mode_w),
      .min_rep_i (chk.min_rep),
      .max_rep_i (chk.max_rep),
      .win_len_i (chk.win_len),
      .a_i       (chk.a[i]),
      .b_i       (chk.b[i]),
      .pass_o    (pass_w[i]),
      .fail_o    (fail_w[i]),
      .drop_o    (drop_w[i]),
      .busy_o    (busy_w[i])
    );
  end

  assign chk.pass = pass_w;
  assign chk.fail = fail_w;
  assign chk.drop = drop_w;
  assign chk.busy = busy_w;

endmodule
